// File: rtl/ikaopll_bus_writer.sv
// OPLL CPU-bus write sequencer: queues {addr,data} requests and plays each one
// out as an address cycle then a data cycle, honouring the chip's post-write waits.
module ikaopll_bus_writer #(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int STROBE_LEN      = 2,
    parameter int ADDR_WAIT       = 12,
    parameter int DATA_WAIT       = 84
) (
    input  logic                     i_EMUCLK,
    input  logic                     i_RST,
    input  logic                     i_phiM_PCEN_n,
    input  logic                     i_REQ_VALID,
    input  logic [7:0]               i_REQ_ADDR,
    input  logic [7:0]               i_REQ_DATA,
    output logic                     o_REQ_READY,
    output logic                     o_CS_n,
    output logic                     o_WR_n,
    output logic                     o_A0,
    output logic [7:0]               o_D,
    output logic                     o_BUSY,
    output logic [FIFO_DEPTH_LOG2:0] o_FIFO_LEVEL
);

    localparam int DEPTH    = 1 << FIFO_DEPTH_LOG2;
    localparam int WAIT_MAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int WCNT_W   = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam int SCNT_W   = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

    // Wait states last WAIT-1 ticks; the setup state that follows supplies the last one.
    localparam logic [SCNT_W-1:0] STRB_LOAD = SCNT_W'(STROBE_LEN - 1);
    localparam logic [WCNT_W-1:0] AW_LOAD   = WCNT_W'(ADDR_WAIT - 2);
    localparam logic [WCNT_W-1:0] DW_LOAD   = WCNT_W'(DATA_WAIT - 2);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2+1)'(DEPTH);

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    typedef enum logic [2:0] {
        IDLE, SETUP_A, STRB_A, WAIT_A, SETUP_D, STRB_D, WAIT_D
    } state_t;

    logic tick;
    logic push, pop, start, has_req, strb_nx;
    req_t mem [DEPTH];
    req_t head;
    logic [FIFO_DEPTH_LOG2-1:0] wptr, rptr;
    logic [FIFO_DEPTH_LOG2:0]   level, level_nx;

    state_t            state, state_nx;
    logic [SCNT_W-1:0] scnt, scnt_nx;
    logic [WCNT_W-1:0] wcnt, wcnt_nx;
    logic [7:0]        dat, dat_nx, d_nx;
    logic              a0_nx;

    assign tick         = ~i_phiM_PCEN_n;
    assign o_REQ_READY  = (level != FULL_LEVEL);
    assign o_FIFO_LEVEL = level;
    assign push         = i_REQ_VALID & o_REQ_READY;
    assign has_req      = (level != '0);
    assign head         = mem[rptr];

    always_ff @(posedge i_EMUCLK) begin
        if (push)
            mem[wptr] <= '{addr: i_REQ_ADDR, data: i_REQ_DATA};
    end

    always_comb begin
        level_nx = level;
        unique case ({push, pop})
            2'b10:   level_nx = level + 1'b1;
            2'b01:   level_nx = level - 1'b1;
            default: level_nx = level;
        endcase
    end

    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        wcnt_nx  = wcnt;
        d_nx     = o_D;
        a0_nx    = o_A0;
        dat_nx   = dat;
        start    = 1'b0;
        pop      = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE:    start = has_req;
                SETUP_A: begin
                    state_nx = STRB_A;
                    scnt_nx  = STRB_LOAD;
                end
                STRB_A: begin
                    if (scnt == '0) begin
                        state_nx = WAIT_A;
                        wcnt_nx  = AW_LOAD;
                    end else begin
                        scnt_nx = scnt - 1'b1;
                    end
                end
                WAIT_A: begin
                    if (wcnt == '0) begin
                        state_nx = SETUP_D;
                        d_nx     = dat;
                        a0_nx    = 1'b1;
                    end else begin
                        wcnt_nx = wcnt - 1'b1;
                    end
                end
                SETUP_D: begin
                    state_nx = STRB_D;
                    scnt_nx  = STRB_LOAD;
                end
                STRB_D: begin
                    if (scnt == '0) begin
                        state_nx = WAIT_D;
                        wcnt_nx  = DW_LOAD;
                    end else begin
                        scnt_nx = scnt - 1'b1;
                    end
                end
                WAIT_D: begin
                    if (wcnt == '0) begin
                        state_nx = IDLE;
                        start    = has_req;
                    end else begin
                        wcnt_nx = wcnt - 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
            // Back-to-back from WAIT_D skips IDLE so the data wait stays exact.
            if (start) begin
                pop      = 1'b1;
                state_nx = SETUP_A;
                d_nx     = head.addr;
                a0_nx    = 1'b0;
                dat_nx   = head.data;
            end
        end
    end

    assign strb_nx = (state_nx == STRB_A) || (state_nx == STRB_D);

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state  <= IDLE;
            scnt   <= '0;
            wcnt   <= '0;
            dat    <= '0;
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            o_CS_n <= 1'b1;
            o_WR_n <= 1'b1;
            o_A0   <= 1'b0;
            o_D    <= '0;
            o_BUSY <= 1'b0;
        end else begin
            state  <= state_nx;
            scnt   <= scnt_nx;
            wcnt   <= wcnt_nx;
            dat    <= dat_nx;
            level  <= level_nx;
            o_CS_n <= ~strb_nx;
            o_WR_n <= ~strb_nx;
            o_A0   <= a0_nx;
            o_D    <= d_nx;
            o_BUSY <= (level_nx != '0) || (state_nx != IDLE);
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Scoreboard bench: stimulus queues expected bus writes with their push tick;
// the monitor checks every bus cycle's pairing, strobe widths and wait gaps.
module tb_ikaopll_bus_writer;

    localparam int SL = 2, AW = 12, DW = 84;
    localparam int NEVER = -1000000;

    logic       clk = 0, rst = 1, pcen_n = 1, valid = 0;
    logic [7:0] addr = 0, data = 0;
    logic       ready, cs_n, wr_n, a0, busy;
    logic [7:0] d;
    logic [3:0] level;

    ikaopll_bus_writer dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen_n),
        .i_REQ_VALID(valid), .i_REQ_ADDR(addr), .i_REQ_DATA(data),
        .o_REQ_READY(ready), .o_CS_n(cs_n), .o_WR_n(wr_n), .o_A0(a0),
        .o_D(d), .o_BUSY(busy), .o_FIFO_LEVEL(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         ptc;
    } req_t;

    req_t exp_q[$];
    int   checks = 0, errors = 0;
    int   tick_cnt = 0, mode = 3, clk_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Tick index: a tick edge gets tick_cnt+1; readable post-edge.
    always @(posedge clk) if (!pcen_n) tick_cnt <= tick_cnt + 1;

    // mode 0: every clock a tick, 1: one in four, 2: random, 3: no ticks
    always @(negedge clk) begin
        clk_cnt++;
        case (mode)
            0:       pcen_n = 1'b0;
            1:       pcen_n = (clk_cnt % 4) != 0;
            2:       pcen_n = 1'($urandom_range(0, 1));
            default: pcen_n = 1'b1;
        endcase
    end

    // Monitor / scoreboard
    logic p_wr = 1, p_cs = 1, p_a0 = 0, p_busy = 0;
    logic [7:0] p_d = 0;
    bit   phase = 0;
    int   fall_t = 0, addr_rise = NEVER, data_rise = NEVER, a0_chg = NEVER;
    req_t cur;

    always begin : mon
        bit tk, rs;
        int t, e;
        @(posedge clk);
        tk = !pcen_n;
        rs = rst;
        #1;
        t = tick_cnt;
        if (rs) begin
            check("rst_cs", cs_n, 1);  check("rst_wr", wr_n, 1);
            check("rst_a0", a0, 0);    check("rst_d", d, 0);
            check("rst_level", level, 0); check("rst_ready", ready, 1);
            check("rst_busy", busy, 0);
            exp_q.delete();
            phase = 0; addr_rise = NEVER; data_rise = NEVER; a0_chg = NEVER;
        end else begin
            if (!tk)
                check("nontick_hold", {cs_n, wr_n, a0, d}, {p_cs, p_wr, p_a0, p_d});
            check("cs_eq_wr", cs_n, wr_n);
            check("ready_vs_level", ready, level != 8);
            check("level_max", level <= 8, 1);
            if (a0 !== p_a0) a0_chg = t;
            if (!wr_n && !p_wr)
                check("stable_in_strobe", {a0, d}, {p_a0, p_d});
            if (!wr_n && p_wr) begin
                fall_t = t;
                if (!phase) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_strobe", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        e = data_rise + DW;
                        if (cur.ptc + 2 > e) e = cur.ptc + 2;
                        check("addr_a0", a0, 0);
                        check("addr_d", d, cur.a);
                        check("addr_fall_tick", t, e);
                    end
                end else begin
                    check("data_a0", a0, 1);
                    check("data_d", d, cur.d);
                    check("addr_gap", t - addr_rise, AW);
                    check("data_setup", a0_chg, t - 1);
                end
            end
            if (wr_n && !p_wr) begin
                check("strobe_width", t - fall_t, SL);
                if (!phase) begin addr_rise = t; phase = 1; end
                else begin data_rise = t; phase = 0; end
            end
            if (!busy && p_busy)
                check("idle_entry", t, data_rise + DW - 1);
        end
        p_wr = wr_n; p_cs = cs_n; p_a0 = a0; p_d = d; p_busy = busy;
    end

    task automatic push(input logic [7:0] a, input logic [7:0] dv, output int waited);
        @(negedge clk);
        valid = 1; addr = a; data = dv; waited = 0;
        forever begin
            @(posedge clk);
            if (ready === 1'b1) begin
                exp_q.push_back('{a, dv, tick_cnt + (pcen_n ? 0 : 1)});
                break;
            end
            waited++;
            if (waited > 5000) begin
                check("push_timeout", 1, 0);
                break;
            end
        end
        #1 valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || phase || busy !== 1'b0) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 40000, 1);
        check("drain_level", level, 0);
        check("drain_cs", cs_n, 1);
    endtask

    initial begin
        int w, n, gap;
        repeat (2) @(negedge clk);
        rst = 0;
        @(posedge clk); #1 mode = 0;

        push(8'h10, 8'h55, w);
        drain();

        push(8'h30, 8'h0F, w);
        push(8'h20, 8'h1C, w);
        drain();

        // fill with ticks stopped, then the first pop frees a slot
        @(posedge clk); #1 mode = 3;
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i), 8'(8'hA0 + i), w);
        check("full_level", level, 8);
        check("full_ready", ready, 0);
        mode = 0;
        push(8'h48, 8'hA8, w);
        check("ninth_wait", w, 1);
        drain();

        @(posedge clk); #1 mode = 1;
        push(8'h11, 8'h22, w);
        push(8'h33, 8'h44, w);
        drain();

        // reset while the first data strobe is low, three entries still queued
        @(posedge clk); #1 mode = 0;
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i), 8'(8'h70 + i), w);
        n = 0;
        while (!(a0 === 1'b1 && wr_n === 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_strb_d", n < 3000, 1);
        check("pre_rst_level", level, 3);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (200) @(negedge clk);
        check("post_rst_busy", busy, 0);

        @(posedge clk); #1 mode = 2;
        for (int i = 0; i < 50; i++) begin
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 250) : $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            push(8'($urandom), 8'($urandom), w);
        end
        drain();
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
